// File: rtl/lc4_div_iter.sv
// Multi-cycle unsigned 16-bit restoring divider for LC4 DIV/MOD.
// One 16-bit carry-lookahead adder performs the trial subtraction of every iteration.

module cla16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;
    logic [15:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Group generate/propagate for each 4-bit slice.
    always_comb begin
        w_gg = '0;
        w_gp = '0;
        for (int k = 0; k < 4; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
    end

    assign w_gc[0] = i_cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

    // Per-bit carries inside each slice, looked ahead from the slice carry-in.
    always_comb begin
        w_c = '0;
        for (int k = 0; k < 4; k++) begin
            w_c[4*k]   = w_gc[k];
            w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
            w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
            w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                       | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[4];
endmodule

module lc4_div_iter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [3:0]   r_count;
    logic [W-1:0] r_q;
    logic [W-1:0] r_r;
    logic [W-1:0] r_div;
    logic         r_dz;

    logic         w_accept;
    logic [W:0]   w_s;
    logic [W-1:0] w_diff;
    logic         w_no_borrow;
    logic         w_ge;

    assign o_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & i_ready);
    assign w_accept = i_valid & o_ready;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign w_s = {r_r, r_q[W-1]};

    cla16 u_cla (
        .i_a    (w_s[W-1:0]),
        .i_b    (~r_div),
        .i_cin  (1'b1),
        .o_sum  (w_diff),
        .o_cout (w_no_borrow)
    );

    // Carry-out of a + ~b + 1 is exactly (a >= b); bit W covers the 17-bit case.
    assign w_ge = w_s[W] | w_no_borrow;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // NOTE: next-state gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY:  if (r_count == 4'd15) w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_accept)     w_state_nxt = S_BUSY;
                else if (i_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an aborted operation
    // cannot leak a partial quotient or remainder onto the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_div   <= '0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_count <= '0;
            r_q     <= i_dividend;
            r_r     <= '0;
            r_div   <= i_divisor;
            r_dz    <= (i_divisor == '0);
        end else if (r_state == S_BUSY) begin
            r_count <= r_count + 4'd1;
            r_q     <= {r_q[W-2:0], w_ge};
            r_r     <= w_ge ? w_diff : w_s[W-1:0];
        end
    end

    // LC4 defines x/0 and x%0 as zero; the latched flag masks the raw result.
    assign o_valid     = (r_state == S_DONE);
    assign o_quotient  = r_dz ? '0 : r_q;
    assign o_remainder = r_dz ? '0 : r_r;
endmodule

// File: tb/tb_lc4_div_iter.sv
// Scoreboard bench for lc4_div_iter: the driver queues expected results on accept,
// the monitor pops and compares whenever a result appears, and checks it holds under stall.

module tb_lc4_div_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [15:0] i_dividend = '0;
    logic [15:0] i_divisor = '0;
    logic        o_ready;
    logic        o_valid;
    logic [15:0] o_quotient;
    logic [15:0] o_remainder;

    lc4_div_iter #(.W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: either a forced level or random stalls (~25% of cycles).
    always @(posedge clk) begin
        #1;
        i_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: first cycle of a result pops the scoreboard; stall cycles must hold it.
    exp_t cur;
    bit   have = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            have = 1'b0;
        end else if (o_valid) begin
            if (!have) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 32'(o_valid), 32'd0);
                end else begin
                    cur  = sb.pop_front();
                    have = 1'b1;
                    check("latency", 32'(cyc), 32'(cur.acc + 16));
                    check("quotient", 32'(o_quotient), 32'(cur.q));
                    check("remainder", 32'(o_remainder), 32'(cur.r));
                end
            end else begin
                check("hold_quotient", 32'(o_quotient), 32'(cur.q));
                check("hold_remainder", 32'(o_remainder), 32'(cur.r));
            end
            if (i_ready) have = 1'b0;
        end else begin
            have = 1'b0;
        end
    end

    // Offer one operation; called just after a rising edge, returns just after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] q, input logic [15:0] r);
        exp_t e;
        int   n;
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            check("accept_timeout", 32'(o_ready), 32'd1);
        end else begin
            e.q   = q;
            e.r   = r;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        i_valid    = 1'b0;
        i_dividend = 16'($urandom);
        i_divisor  = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || o_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || o_valid) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'(1 + $urandom_range(0, 15));
            3:       return 16'($urandom_range(1, 255));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        logic [15:0] b;

        // Reset state.
        #12;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_quotient", 32'(o_quotient), 32'd0);
        check("rst_remainder", 32'(o_remainder), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic and extreme operands.
        issue(16'd100, 16'd7, 16'd14, 16'd2);
        drain();
        issue(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000);
        drain();
        issue(16'h1234, 16'hFFFF, 16'h0000, 16'h1234);
        drain();
        issue(16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000);
        drain();
        issue(16'h00AB, 16'h0000, 16'h0000, 16'h0000);
        drain();

        // Backpressure for 10+ cycles, then drain and accept on the same edge.
        rdy_force = 1'b0;
        issue(16'd50, 16'd5, 16'd10, 16'd0);
        for (int n = 0; n < 40 && !o_valid; n++) @(negedge clk);
        check("bp_valid", 32'(o_valid), 32'd1);
        repeat (10) @(negedge clk);
        rdy_force = 1'b1;
        @(posedge clk);
        #1;
        issue(16'd9, 16'd4, 16'd2, 16'd1);
        @(negedge clk);
        check("b2b_no_idle_valid", 32'(o_valid), 32'd0);
        check("b2b_no_idle_ready", 32'(o_ready), 32'd0);
        drain();

        // Reset in the middle of an operation.
        issue(16'd1000, 16'd3, 16'd333, 16'd1);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        sb.delete();
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_quotient", 32'(o_quotient), 32'd0);
        check("abort_remainder", 32'(o_remainder), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_idle_valid", 32'(o_valid), 32'd0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;

        // Short random phase with random downstream stalls.
        rdy_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a = pick();
            b = pick();
            issue(a, b, (b == 16'd0) ? 16'd0 : a / b, (b == 16'd0) ? 16'd0 : a % b);
        end
        drain();
        rdy_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
